// File: rtl/aes_tcdm_responder.sv
// -----------------------------------------------------------------------------
// aes_tcdm_responder
//   Single-bank TCDM slave memory standing in for the cluster TCDM next to the
//   AES HWPE streamer. Arbitrates MP master ports round-robin (one grant per
//   cycle), performs byte-enabled writes and answers every granted transaction
//   with exactly one r_valid pulse one cycle later. A backdoor port preloads
//   memory, and stall_i lets the environment inject back-pressure.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   tcdm_req_i        per-port request
//   tcdm_gnt_o        per-port grant, combinational from the current request
//   tcdm_add_i        per-port byte address
//   tcdm_wen_i        per-port 1 = read, 0 = write
//   tcdm_be_i         per-port byte enables (writes only)
//   tcdm_data_i       per-port write data
//   tcdm_r_data_o     per-port response data (0 when not valid, 0 for writes)
//   tcdm_r_valid_o    per-port response strobe
//   stall_i           suppresses all grants while high
//   bd_we_i           backdoor write strobe; suppresses all grants while high
//   bd_addr_i         backdoor word index
//   bd_data_i         backdoor full-word write data
//   access_cnt_o      granted transactions, wraps at 2^32
//   err_cnt_o         out-of-range granted transactions, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module aes_tcdm_responder #(
    parameter int          MP        = 2,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [MP-1:0]              tcdm_req_i,
    output logic [MP-1:0]              tcdm_gnt_o,
    input  logic [MP-1:0][31:0]        tcdm_add_i,
    input  logic [MP-1:0]              tcdm_wen_i,
    input  logic [MP-1:0][3:0]         tcdm_be_i,
    input  logic [MP-1:0][31:0]        tcdm_data_i,
    output logic [MP-1:0][31:0]        tcdm_r_data_o,
    output logic [MP-1:0]              tcdm_r_valid_o,
    input  logic                       stall_i,
    input  logic                       bd_we_i,
    input  logic [$clog2(DEPTH)-1:0]   bd_addr_i,
    input  logic [31:0]                bd_data_i,
    output logic [31:0]                access_cnt_o,
    output logic [15:0]                err_cnt_o
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          RRW  = (MP > 1) ? $clog2(MP) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;  // address window in bytes

    logic [31:0]            mem_q [DEPTH];

    logic [RRW-1:0]         rr_q, rr_d;
    logic [MP-1:0]          rvalid_q, rvalid_d;
    logic [MP-1:0][31:0]    rdata_q, rdata_d;
    logic [31:0]            access_cnt_q, access_cnt_d;
    logic [15:0]            err_cnt_q, err_cnt_d;

    logic [MP-1:0]          gnt;
    logic                   gnt_any;
    logic [RRW-1:0]         gnt_idx;

    logic [31:0]            sel_add, sel_data, offset;
    logic [3:0]             sel_be;
    logic                   sel_wen, in_range, mem_we;
    logic [AW-1:0]          word_idx;

    // Round-robin search starting at rr_q, wrapping around.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin : arbiter
        int             c;
        logic [RRW-1:0] cand;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_d    = rr_q;
        c       = 0;
        cand    = '0;
        if (!(rst_i || stall_i || bd_we_i)) begin
            for (int i = 0; i < MP; i++) begin
                c = int'(rr_q) + i;
                if (c >= MP) c = c - MP;
                cand = RRW'(c);
                if (!gnt_any && tcdm_req_i[cand]) begin
                    gnt_any   = 1'b1;
                    gnt_idx   = cand;
                    gnt[cand] = 1'b1;
                    rr_d      = (c + 1 >= MP) ? '0 : RRW'(c + 1);
                end
            end
        end
    end

    // Decode of the single granted transaction.
    assign sel_add  = tcdm_add_i[gnt_idx];
    assign sel_data = tcdm_data_i[gnt_idx];
    assign sel_be   = tcdm_be_i[gnt_idx];
    assign sel_wen  = tcdm_wen_i[gnt_idx];
    assign offset   = sel_add - BASE_ADDR;
    assign in_range = (sel_add >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign word_idx = offset[AW+1:2];
    assign mem_we   = gnt_any && !sel_wen && in_range;

    always_comb begin
        rvalid_d     = '0;
        rdata_d      = '0;
        access_cnt_d = access_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (gnt_any) begin
            rvalid_d[gnt_idx] = 1'b1;
            // Memory is sampled before the grant edge, so a write granted in
            // the previous cycle is already visible here.
            if (sel_wen) rdata_d[gnt_idx] = in_range ? mem_q[word_idx] : ERR_DATA;
            access_cnt_d = access_cnt_q + 32'd1;
            if (!in_range && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q         <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            access_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            rr_q         <= rr_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            access_cnt_q <= access_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM; contents
    // survive rst_i. Backdoor and TCDM writes never coincide because bd_we_i
    // blocks all grants.
    always_ff @(posedge clk_i) begin
        if (bd_we_i) begin
            mem_q[bd_addr_i] <= bd_data_i;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_be[b]) mem_q[word_idx][8*b +: 8] <= sel_data[8*b +: 8];
            end
        end
    end

    // A response registered just before reset asserts is dropped rather than
    // presented while rst_i is high.
    assign tcdm_gnt_o     = gnt;
    assign tcdm_r_valid_o = rst_i ? '0 : rvalid_q;
    assign tcdm_r_data_o  = rst_i ? '0 : rdata_q;
    assign access_cnt_o   = access_cnt_q;
    assign err_cnt_o      = err_cnt_q;

endmodule

// File: doc/aes_tcdm_responder.md
Name: aes_tcdm_responder

Overview:
- Single-bank TCDM slave memory that answers the MP TCDM master ports driven by the AES HWPE streamer.
- Sits beside the accelerator in the block-level environment and stands in for the cluster TCDM.
- Provides round-robin arbitration, byte-enabled writes and a fixed one-cycle read response.
- Provides a backdoor preload port and a stall input so the bench can inject back-pressure.

Parameters:
- MP, 2, number of TCDM slave ports.
- DEPTH, 1024, memory size in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned.
- ERR_DATA, 32'hDEAD_BEEF, read data returned for out-of-range reads.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- tcdm_req_i  in  MP  per-port request.
- tcdm_gnt_o  out  MP  per-port grant; combinational from req, same cycle.
- tcdm_add_i  in  MPx32  byte address.
- tcdm_wen_i  in  MP  1 = read, 0 = write.
- tcdm_be_i  in  MPx4  byte enables; writes only.
- tcdm_data_i  in  MPx32  write data.
- tcdm_r_data_o  out  MPx32  response data.
- tcdm_r_valid_o  out  MP  response strobe.
- stall_i  in  1  when high, no grant is issued.
- bd_we_i  in  1  backdoor write strobe.
- bd_addr_i  in  clog2(DEPTH)  backdoor word index.
- bd_data_i  in  32  backdoor write data; full word.
- access_cnt_o  out  32  number of granted TCDM transactions.
- err_cnt_o  out  16  number of out-of-range transactions.

Behaviour:
- Reset values while rst_i is high (synchronous):
  - tcdm_gnt_o = 0, tcdm_r_valid_o = 0, tcdm_r_data_o = 0.
  - access_cnt_o = 0, err_cnt_o = 0, round-robin pointer rr_q = 0.
  - Memory contents are not reset.
- Reset mid-operation: a response pending from the previous cycle is dropped; r_valid stays 0 in the cycle after reset deasserts.
- Arbitration:
  - At most one grant per cycle.
  - No grant when rst_i, stall_i or bd_we_i is high.
  - Otherwise grant the first requesting port at index >= rr_q, searching upward with wrap-around.
  - On a grant to port k, rr_q <= (k+1) mod MP. Without a grant, rr_q holds.
- Address decode:
  - offset = add - BASE_ADDR; word index = offset[clog2(DEPTH)+1:2]; add[1:0] ignored.
  - A transaction is in range if add >= BASE_ADDR and offset < DEPTH*4.
- Granted write, in range: the byte lanes with be set are updated at the clock edge. be = 0 is legal and changes nothing.
- Granted write, out of range: memory is unchanged and err_cnt increments.
- Granted read: memory is sampled at the grant edge.
  - Next cycle: r_valid[k] = 1 and r_data[k] = the word, or ERR_DATA if out of range (err_cnt also increments).
- Every granted transaction, read or write, produces exactly one r_valid pulse on its own port one cycle later.
  - For a write, r_data = 0.
  - Latency is fixed at 1; there is no r_ready.
- r_data on non-valid ports is driven 0.
- Read-after-write to the same word in consecutive cycles returns the new data. A same-cycle conflict cannot occur because only one grant is issued per cycle.
- Backdoor: bd_we_i writes bd_data_i to bd_addr_i and blocks all grants in that cycle. Backdoor writes do not increment either counter.
- Counters:
  - access_cnt increments on every grant and wraps at 2^32.
  - err_cnt saturates at 16'hFFFF.
- Requests without a grant must be held by the master. The responder keeps no memory of ungranted requests.

Test Plan:
- Backdoor preload word 5 = 32'h0123_4567, then a port0 read at add 0x14 -> gnt0 same cycle; next cycle r_valid0 = 1, r_data0 = 32'h0123_4567; access_cnt = 1.
- Port1 write 0x14, data 32'hAABB_CCDD, be = 4'b0101, over the preloaded word; then read 0x14 -> r_valid after the write, r_data = 32'h01BB_45DD on the read's response.
- Both ports request reads continuously for 4 cycles from reset -> grants in order p0, p1, p0, p1; each r_valid exactly one cycle after its grant; access_cnt = 4.
- stall_i high for 3 cycles with port0 requesting -> gnt0 = 0 for those 3 cycles; granted in the first cycle after stall drops; rr_q unchanged during the stall.
- Read at add BASE_ADDR + 4*DEPTH (0x1000) and write at 0x1004 -> responses r_data = 32'hDEAD_BEEF and r_data = 0 respectively; err_cnt = 2; memory untouched.
- Read granted, rst_i asserted on the next edge -> no r_valid is observed; all counters = 0; a subsequent read of the same word returns the unchanged memory content.
